// File: rtl/npc_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, reset PC,
// AXI read-response codes and the canonical NOP instruction.
package npc_pkg;

  typedef enum logic [1:0] {
    S_AR,
    S_R,
    S_HOLD,
    S_WPC
  } ifu_state_t;

  localparam logic [31:0] RESET_PC        = 32'h8000_0000;
  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;
  localparam logic [31:0] NOP_INST        = 32'h0000_0013;

  function automatic logic resp_is_fault(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/ifu_perf_cnt.sv
// Fetch-stage performance counters: completed fetches and cycles spent waiting
// on memory. Both are free-running 64-bit counters that wrap.
module ifu_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_evt,
  input  logic        stall_evt,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (fetch_evt) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (stall_evt) perf_stall_cnt <= perf_stall_cnt + 64'd1;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Non-pipelined instruction fetch: one AXI-lite read in flight, instruction held
// for decode, then waits for the next PC. Optional counters under IFU_PERF_CNT_EN.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(npc_pkg::RESET_PC)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] araddr,
  output logic             arvalid,
  input  logic             arready,
  input  logic [31:0]      rdata,
  input  logic [1:0]       rresp,
  input  logic             rvalid,
  output logic             rready,
  output logic [WIDTH-1:0] pc,
  output logic [31:0]      inst,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic             inst_fault,
  input  logic             pc_upd_valid,
  input  logic [WIDTH-1:0] pc_upd
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]      perf_fetch_cnt,
  output logic [63:0]      perf_stall_cnt
`endif
);

  ifu_state_t       state;
  logic [WIDTH-1:0] pc_reg;
  logic [31:0]      inst_reg;
  logic             fault_reg;
  logic             arvalid_reg;
  logic             rready_reg;
  logic             inst_valid_reg;

  // Handshake flags are registered alongside the state so every output is a
  // flop; arvalid stays low for the first cycle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_AR;
      pc_reg         <= RESET_PC;
      inst_reg       <= NOP_INST;
      fault_reg      <= 1'b0;
      arvalid_reg    <= 1'b0;
      rready_reg     <= 1'b0;
      inst_valid_reg <= 1'b0;
    end else begin
      case (state)
        S_AR: begin
          arvalid_reg <= 1'b1;
          if (arvalid_reg && arready) begin
            state       <= S_R;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
          end
        end
        S_R: begin
          if (rvalid && rready_reg) begin
            inst_reg       <= rdata;
            fault_reg      <= resp_is_fault(rresp);
            state          <= S_HOLD;
            rready_reg     <= 1'b0;
            inst_valid_reg <= 1'b1;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            state          <= S_WPC;
            inst_valid_reg <= 1'b0;
          end
        end
        S_WPC: begin
          if (pc_upd_valid) begin
            pc_reg      <= {pc_upd[WIDTH-1:2], 2'b00};
            state       <= S_AR;
            arvalid_reg <= 1'b1;
          end
        end
        default: begin
          state          <= S_AR;
          arvalid_reg    <= 1'b0;
          rready_reg     <= 1'b0;
          inst_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign araddr     = pc_reg;
  assign arvalid    = arvalid_reg;
  assign rready     = rready_reg;
  assign pc         = pc_reg;
  assign inst       = inst_reg;
  assign inst_valid = inst_valid_reg;
  assign inst_fault = fault_reg;

`ifdef IFU_PERF_CNT_EN
  ifu_perf_cnt u_perf_cnt (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_evt      (rvalid && rready_reg),
    .stall_evt      ((state == S_AR) || (state == S_R)),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the fetch stage.
module tb_ifu_fetch;

  localparam int WIDTH = 32;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] araddr;
  logic             arvalid;
  logic             arready;
  logic [31:0]      rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready;
  logic [WIDTH-1:0] pc;
  logic [31:0]      inst;
  logic             inst_valid;
  logic             inst_ready;
  logic             inst_fault;
  logic             pc_upd_valid;
  logic [WIDTH-1:0] pc_upd;
`ifdef IFU_PERF_CNT_EN
  logic [63:0]      perf_fetch_cnt;
  logic [63:0]      perf_stall_cnt;
`endif

  ifu_fetch #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .araddr       (araddr),
    .arvalid      (arvalid),
    .arready      (arready),
    .rdata        (rdata),
    .rresp        (rresp),
    .rvalid       (rvalid),
    .rready       (rready),
    .pc           (pc),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_fault   (inst_fault),
    .pc_upd_valid (pc_upd_valid),
    .pc_upd       (pc_upd)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level model: which phase of the single outstanding fetch we are in.
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        m_fault;
  logic        m_pending;
  logic        m_holding;
  logic        m_waiting;
  logic        m_first;
  longint      m_fetches;
  longint      m_stalls;
  logic        prev_ok;
  logic        prev_arvalid;
  logic        prev_arready;
  logic [31:0] prev_araddr;
  int          ar_seen_cyc;
  int          cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = RST_PC;
    m_inst    = 32'h0000_0013;
    m_fault   = 1'b0;
    m_pending = 1'b0;
    m_holding = 1'b0;
    m_waiting = 1'b0;
    m_first   = 1'b1;
    m_fetches = 0;
    m_stalls  = 0;
    prev_ok   = 1'b0;
  endtask

  task automatic check_outputs();
    logic idle;
    idle = !m_pending && !m_holding && !m_waiting;
    chk("one_phase", 64'(int'(arvalid) + int'(rready) + int'(inst_valid) <= 1), 64'd1);
    chk("arvalid", 64'(arvalid), 64'(idle && !m_first));
    chk("rready", 64'(rready), 64'(m_pending));
    chk("inst_valid", 64'(inst_valid), 64'(m_holding));
    if (arvalid) chk("araddr", 64'(araddr), 64'(m_pc));
    if (inst_valid) begin
      chk("inst", 64'(inst), 64'(m_inst));
      chk("inst_fault", 64'(inst_fault), 64'(m_fault));
      chk("pc", 64'(pc), 64'(m_pc));
    end
    if (prev_ok && prev_arvalid && !prev_arready) begin
      chk("arvalid_stable", 64'(arvalid), 64'd1);
      chk("araddr_stable", 64'(araddr), 64'(prev_araddr));
    end
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, 64'(m_fetches));
    chk("perf_stall", perf_stall_cnt, 64'(m_stalls));
`endif
  endtask

  // Apply the handshakes that the coming clock edge will complete.
  task automatic update_model();
    if (!m_holding && !m_waiting) m_stalls++;
    if (m_waiting && pc_upd_valid) begin
      m_pc      = {pc_upd[31:2], 2'b00};
      m_waiting = 1'b0;
    end
    if (arvalid && arready) m_pending = 1'b1;
    if (rready && rvalid) begin
      m_inst    = rdata;
      m_fault   = (rresp != 2'b00);
      m_pending = 1'b0;
      m_holding = 1'b1;
      m_fetches++;
    end
    if (inst_valid && inst_ready) begin
      m_holding = 1'b0;
      m_waiting = 1'b1;
    end
    m_first      = 1'b0;
    prev_ok      = 1'b1;
    prev_arvalid = arvalid;
    prev_arready = arready;
    prev_araddr  = araddr;
  endtask

  task automatic step();
    check_outputs();
    update_model();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_inputs();
    arready      = 1'b0;
    rvalid       = 1'b0;
    rdata        = 32'h0;
    rresp        = 2'b00;
    inst_ready   = 1'b0;
    pc_upd_valid = 1'b0;
    pc_upd       = 32'h0;
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'h0000_0013);
    chk("rst_fault", 64'(inst_fault), 64'd0);
    chk("rst_pc", 64'(pc), 64'h8000_0000);
    rst_n = 1'b1;
    model_reset();

    // Zero-wait first fetch
    arready = 1'b1;
    step();
    chk("t1_arvalid", 64'(arvalid), 64'd1);
    chk("t1_araddr", 64'(araddr), 64'h8000_0000);
    ar_seen_cyc = cyc;
    rvalid = 1'b1; rdata = 32'h0010_0093; rresp = 2'b00;
    step();
    arready = 1'b0;
    step();
    chk("t1_inst_valid", 64'(inst_valid), 64'd1);
    chk("t1_latency", 64'(cyc - ar_seen_cyc), 64'd2);
    chk("t1_inst", 64'(inst), 64'h0010_0093);
    chk("t1_fault", 64'(inst_fault), 64'd0);

    // Decode stalls while read data keeps toggling
    for (int i = 0; i < 3; i++) begin
      rdata = $urandom;
      rresp = 2'(i);
      step();
      chk("t3_inst", 64'(inst), 64'h0010_0093);
      chk("t3_pc", 64'(pc), 64'h8000_0000);
      chk("t3_valid", 64'(inst_valid), 64'd1);
    end
    rvalid = 1'b0;

    // Next-PC update outside the wait phase is dropped
    pc_upd_valid = 1'b1; pc_upd = 32'h1234_5678;
    step();
    chk("t4_ignored_pc", 64'(pc), 64'h8000_0000);
    pc_upd_valid = 1'b0; inst_ready = 1'b1;
    step();
    chk("t4_valid_drop", 64'(inst_valid), 64'd0);
    inst_ready = 1'b0; pc_upd_valid = 1'b1; pc_upd = 32'h8000_0107;
    step();
    pc_upd_valid = 1'b0;
    chk("t4_arvalid", 64'(arvalid), 64'd1);
    chk("t4_araddr", 64'(araddr), 64'h8000_0104);

    // Address channel back-pressure
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_arvalid", 64'(arvalid), 64'd1);
      chk("t2_araddr", 64'(araddr), 64'h8000_0104);
    end
`ifdef IFU_PERF_CNT_EN
    chk("t2_stall_ge5", 64'(perf_stall_cnt >= 64'd5), 64'd1);
`endif

    // Error response sets the fault flag, next OKAY clears it
    arready = 1'b1;
    step();
    arready = 1'b0; rvalid = 1'b1; rresp = 2'b10; rdata = 32'hdead_beef;
    step();
    chk("t5_fault_set", 64'(inst_fault), 64'd1);
    chk("t5_inst", 64'(inst), 64'hdead_beef);
    rvalid = 1'b0; rresp = 2'b00; inst_ready = 1'b1;
    step();
    inst_ready = 1'b0; pc_upd_valid = 1'b1; pc_upd = 32'h8000_0200;
    step();
    pc_upd_valid = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0013;
    step();
    chk("t5_fault_clr", 64'(inst_fault), 64'd0);
    chk("t5_pc", 64'(pc), 64'h8000_0200);
    rvalid = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      arready      = ($urandom_range(0, 1) == 1);
      rvalid       = ($urandom_range(0, 2) != 0);
      rdata        = $urandom;
      rresp        = 2'($urandom_range(0, 3));
      inst_ready   = ($urandom_range(0, 1) == 1);
      pc_upd_valid = ($urandom_range(0, 3) == 0);
      pc_upd       = $urandom;
      step();
    end

    // Reset while a read is outstanding
    idle_inputs();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (rready) found = 1'b1;
      else begin
        arready    = 1'b1;
        inst_ready = 1'b1;
        pc_upd_valid = 1'b1;
        pc_upd     = $urandom;
        step();
      end
    end
    chk("t6_reached_read", 64'(found), 64'd1);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_arvalid", 64'(arvalid), 64'd0);
    chk("t6_rready", 64'(rready), 64'd0);
    chk("t6_inst_valid", 64'(inst_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
    step();
    chk("t6_arvalid_after", 64'(arvalid), 64'd1);
    chk("t6_araddr_after", 64'(araddr), 64'h8000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
